// File: rtl/seq_detect_pkg.sv
// Shared limits and defaults for the parametrised serial pattern detector.
package seq_detect_pkg;

    localparam int unsigned PatWMin     = 2;
    localparam int unsigned PatWMax     = 16;
    localparam int unsigned PatWDefault = 3;
    localparam logic [PatWDefault-1:0] PatDefault = 3'b101;
    localparam int unsigned CntWDefault = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detect_par.sv
// Detector implementation lives in seq_detect_param.sv.

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern, overlap select and a
// saturating match counter. Prefix length is recomputed from the bit history.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned      PAT_W       = PatWDefault,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(PatDefault),
    parameter int unsigned      CNT_W       = CntWDefault
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid_i,
    input  logic                         in_bit_i,
    input  logic                         overlap_i,
    input  logic                         pat_load_i,
    input  logic [PAT_W-1:0]             pat_value_i,
    input  logic                         count_clr_i,
    output logic                         match_o,
    output logic [CNT_W-1:0]             match_count_o,
    output logic [$clog2(PAT_W+1)-1:0]   prefix_len_o
);

    localparam int unsigned LenW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LenW-1:0]  fill_q, fill_d;
    logic [LenW-1:0]  len_q, len_d;
    logic             match_q, match_d;

    logic [PAT_W-1:0] hist_shift;
    logic [LenW-1:0]  fill_inc;
    logic [LenW-1:0]  k_new;
    logic [PAT_W-1:0] mask;

    // hist_shift[0] is the newest bit; fill tracks how many history bits are real.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], in_bit_i};
        fill_inc   = (fill_q == LenW'(PAT_W)) ? fill_q : fill_q + LenW'(1);
        k_new      = '0;
        mask       = '0;
        for (int k = 1; k <= PAT_W; k++) begin
            mask = {PAT_W{1'b1}} >> (PAT_W - k);
            if ((LenW'(k) <= fill_inc) &&
                (((hist_shift ^ (pat_q >> (PAT_W - k))) & mask) == '0)) begin
                k_new = LenW'(k);
            end
        end
    end

    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        len_d   = len_q;
        match_d = 1'b0;
        if (pat_load_i) begin
            pat_d  = pat_value_i;
            hist_d = '0;
            fill_d = '0;
            len_d  = '0;
        end else if (in_valid_i) begin
            match_d = (k_new == LenW'(PAT_W));
            if (match_d && !overlap_i) begin
                hist_d = '0;
                fill_d = '0;
                len_d  = '0;
            end else begin
                hist_d = hist_shift;
                fill_d = fill_inc;
                len_d  = k_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= PAT_DEFAULT;
            hist_q  <= '0;
            fill_q  <= '0;
            len_q   <= '0;
            match_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            len_q   <= len_d;
            match_q <= match_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_count (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (match_d),
        .clr_i   (count_clr_i),
        .count_o (match_count_o)
    );

    assign match_o      = match_q;
    assign prefix_len_o = len_q;

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector with per-cycle input qualification, a runtime-loadable pattern, selectable overlapping or non-overlapping matching, and a saturating match counter. It sits on single-bit serial streams in the sample-design library as the general-purpose successor to the fixed three-bit Moore detectors. With PAT_W=3, pattern 3'b101 and overlap=1 it reproduces the fixed "101" overlapping detector when in_valid is held high.

## Interface
- PAT_W, 3: pattern length in bits, 2..16.
- PAT_DEFAULT, 3'b101: pattern loaded at reset; bit PAT_W-1 is the first bit received.
- CNT_W, 8: width of match_count.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  qualifies in_bit; when low, all state holds.
- in_bit  in  1  serial data bit.
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping; sampled every accepted bit.
- pat_load  in  1  load pat_value as the new pattern.
- pat_value  in  PAT_W  pattern to load.
- count_clr  in  1  clear match_count.
- match  out  1  registered one-cycle pulse per detected match.
- match_count  out  CNT_W  saturating count of matches.
- prefix_len  out  $clog2(PAT_W+1)  current matched-prefix length, 0..PAT_W.

## Operation
- Reset: pattern=PAT_DEFAULT, prefix_len=0, match=0, match_count=0, and the bit history is empty.
- State is prefix_len, the length of the longest pattern prefix that is a suffix of the accepted bits. The pattern is runtime-loadable, so the next-state logic is computed generically from the bit history and the pattern, not from a hard-coded case table.
- On an accepted bit (in_valid=1):
  - New length k is the largest k ≤ PAT_W such that the last k accepted bits equal pattern bits [PAT_W-1 : PAT_W-k].
  - If k==PAT_W, a match occurs: match=1 on the next cycle and match_count increments.
  - After a match with overlap=1, state continues from the longest proper prefix that is also a suffix (for 101 this is length 1).
  - After a match with overlap=0, prefix_len=0 and the history is cleared.
- in_valid=0: prefix_len, history and match_count hold, and match=0.
- pat_load=1: the pattern is replaced, prefix_len=0, the history is cleared and match=0 on the next cycle. If in_valid is also high that cycle, pat_load wins and in_bit is discarded.
- count_clr=1: match_count=0 on the next cycle. If a match occurs in the same cycle, the clear wins but the match pulse is still emitted.
- match_count saturates at 2^CNT_W-1 and does not wrap.
- reset has priority over every other input, including mid-match.

## Timing
- Latency: match rises at the clock edge that accepts the completing bit and falls one cycle later unless the next accepted bit completes another match. The output is Moore style, with no combinational path from in_bit to match.
- prefix_len and match_count update at the same edge as match.
- Back-to-back matches are possible every cycle only when the pattern permits it (for example all-ones with overlap=1).
- No handshake back-pressure: every in_valid cycle is consumed.

## Structure
- Package seq_detect_pkg: PAT_W limits, the default pattern constant, and the CNT_W default.
- Sub-module sat_counter (CNT_W wide, with inc and clr inputs; clr wins) implements match_count.
- The top level holds the pattern register, the PAT_W-bit history shift register, the valid-bit fill counter, the prefix-length computation and the match register.

## Test plan
- Reset, then in_valid=1 with bits 1,0,1,0,1 and default 101, overlap=1 → match pulses after the 3rd and 5th bits, match_count=2, prefix_len sequence 1,2,3,2,3.
- Same stream with overlap=0 → a single match after the 3rd bit, match_count=1, prefix_len after the 5th bit = 1.
- Bits 1,0 then in_valid=0 for 4 cycles, then bit 1 → prefix_len holds at 2, match=0 while idle, one match on the final bit.
- pat_load with pat_value=3'b110 in the same cycle as in_valid=1, in_bit=1 → bit discarded, prefix_len=0. Then 1,1,0 → one match.
- CNT_W=2, overlap=1, pattern 3'b111, seven consecutive 1s → five matches, match_count saturates at 3. Then count_clr coinciding with a match → count=0 and match pulse still present.
- Assert reset mid-pattern after bits 1,0 → prefix_len=0, match=0, match_count=0, pattern restored to 101 even if a different pattern was loaded.
